// File: rtl/mc_seq_pkg.sv
// mc_seq_pkg: shared types and constants for the multicycle sequencer.
package mc_seq_pkg;

    // Sequencer states; the encoding is fixed so it can be observed on a debug bus.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    // PC source select values.
    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

    // Decoder flags captured in DECODE and used by the later stages.
    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_read;
        logic branch;
        logic jump;
    } dec_flags_t;

    // True while an instruction is in flight.
    function automatic logic is_busy(input state_e s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) ||
               (s == ST_MEM)   || (s == ST_WB);
    endfunction

endpackage

// File: rtl/mc_seq_ctrl_if.sv
// mc_seq_ctrl_if: memory handshakes, decoder flags and datapath controls
// between the sequencer (master) and the datapath/memory side (slave).
interface mc_seq_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             imem_req;
    logic             imem_rdy;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_rdy;
    logic             dec_halt;
    logic             dec_reg_write;
    logic             dec_mem_write;
    logic             dec_mem_read;
    logic             dec_branch;
    logic             dec_jump;
    logic             br_taken;
    logic             ir_load;
    logic             pc_load;
    logic [1:0]       pc_sel;
    logic             rf_we;
    logic             busy;
    logic             halted;
    logic             err;
    logic             retired;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output imem_req, dmem_req, dmem_we, ir_load, pc_load, pc_sel, rf_we,
               busy, halted, err, retired, retired_cnt,
        input  imem_rdy, dmem_rdy, dec_halt, dec_reg_write, dec_mem_write,
               dec_mem_read, dec_branch, dec_jump, br_taken
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we, ir_load, pc_load, pc_sel, rf_we,
               busy, halted, err, retired, retired_cnt,
        output imem_rdy, dmem_rdy, dec_halt, dec_reg_write, dec_mem_write,
               dec_mem_read, dec_branch, dec_jump, br_taken
    );

endinterface

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: counts consecutive cycles a memory request waits for
// ready; expired flags the last allowed waiting cycle so the sequencer can
// leave for ERR on the next edge. MEM_TIMEOUT=0 disables expiry.
module mem_timeout_cnt #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic req,
    input  logic rdy,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [TO_W-1:0] cnt_d, cnt_q;

    // Clear on entry or any ready; count waiting cycles, never wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || rdy) begin
            cnt_d = '0;
        end else if (req && (cnt_q != {TO_W{1'b1}})) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready arriving in the final waiting cycle still wins.
    assign expired = (MEM_TIMEOUT != 0) && req && !rdy && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multicycle sequencer stepping the datapath through
// fetch/decode/execute/memory/writeback with memory-timeout detection.
// Optional feature macro MC_SEQ_PERF_CNT_EN: saturating retired-instruction
// counter; without it retired_cnt reads as zero.
module mc_seq_ctrl
    import mc_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 32
) (
    input logic           clk,
    input logic           rst,
    mc_seq_ctrl_if.master bus
);

    state_e     state_d, state_q;
    dec_flags_t flags_d, flags_q;

    logic       to_clr, to_req, to_rdy, to_expired;

    logic       imem_req, dmem_req, dmem_we, ir_load, pc_load, rf_we, retired;
    logic [1:0] pc_sel;

    // Route the handshake of whichever request is outstanding to the timer.
    always_comb begin
        to_req = (state_q == ST_FETCH) || (state_q == ST_MEM);
        to_rdy = 1'b0;
        if (state_q == ST_FETCH) begin
            to_rdy = bus.imem_rdy;
        end else if (state_q == ST_MEM) begin
            to_rdy = bus.dmem_rdy;
        end
        to_clr = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));
    end

    mem_timeout_cnt #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (to_clr),
        .req     (to_req),
        .rdy     (to_rdy),
        .expired (to_expired)
    );

    // Next-state logic and decoder-flag capture.
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (to_expired) begin
                    state_d = ST_ERR;
                end else if (bus.imem_rdy) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                flags_d.reg_write = bus.dec_reg_write;
                flags_d.mem_write = bus.dec_mem_write;
                flags_d.mem_read  = bus.dec_mem_read;
                flags_d.branch    = bus.dec_branch;
                flags_d.jump      = bus.dec_jump;
                state_d = bus.dec_halt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (flags_q.mem_write || flags_q.mem_read) begin
                    state_d = ST_MEM;
                end else if (flags_q.reg_write) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (to_expired) begin
                    state_d = ST_ERR;
                end else if (bus.dmem_rdy) begin
                    // A store wins when both load and store are flagged.
                    state_d = flags_q.mem_write ? ST_FETCH : ST_WB;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Datapath controls and handshakes decoded from state and inputs.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_load  = 1'b0;
        pc_load  = 1'b0;
        pc_sel   = PC_SEL_SEQ;
        rf_we    = 1'b0;
        retired  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = bus.imem_rdy;
            end
            ST_EXEC: begin
                pc_load = 1'b1;
                if (flags_q.jump) begin
                    pc_sel = PC_SEL_JMP;
                end else if (flags_q.branch && bus.br_taken) begin
                    pc_sel = PC_SEL_BR;
                end
                retired = !(flags_q.mem_write || flags_q.mem_read || flags_q.reg_write);
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = flags_q.mem_write;
                retired  = bus.dmem_rdy && flags_q.mem_write;
            end
            ST_WB: begin
                rf_we   = 1'b1;
                retired = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.imem_req = imem_req;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign bus.ir_load  = ir_load;
    assign bus.pc_load  = pc_load;
    assign bus.pc_sel   = pc_sel;
    assign bus.rf_we    = rf_we;
    assign bus.retired  = retired;
    assign bus.busy     = is_busy(state_q);
    assign bus.halted   = (state_q == ST_HALT);
    assign bus.err      = (state_q == ST_ERR);

`ifdef MC_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] retired_cnt_d, retired_cnt_q;

    // Saturating count of retired instructions; only reset clears it.
    always_comb begin
        retired_cnt_d = retired_cnt_q;
        if (retired && (retired_cnt_q != {CNT_W{1'b1}})) begin
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
        end
    end

    // Retired-count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign bus.retired_cnt = retired_cnt_q;
`else
    assign bus.retired_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// tb_mc_seq_ctrl: instruction-level reference model for mc_seq_ctrl. Each
// instruction is expanded into its expected per-cycle control trace from the
// sequencing rules; unrelated inputs carry random noise every cycle.
module tb_mc_seq_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int TMO     = 15;

    typedef struct {
        int rw, mr, mw, br, jmp, bt, halt;
        int iwait;   // cycles before imem_rdy (>= TMO never arrives)
        int dwait;   // cycles before dmem_rdy (>= TMO never arrives)
        int rst_at;  // MEM cycle in which reset is applied, -1 for none
    } instr_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   exp_cnt;

    mc_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mc_seq_ctrl #(
        .MEM_TIMEOUT (TMO),
        .TO_W        (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int cnt_expected();
`ifdef MC_SEQ_PERF_CNT_EN
        return exp_cnt;
`else
        return 0;
`endif
    endfunction

    // Noise on every input; callers override what the current phase needs.
    task automatic rand_in();
        bus.imem_rdy      = 1'($urandom);
        bus.dmem_rdy      = 1'($urandom);
        bus.dec_halt      = 1'($urandom);
        bus.dec_reg_write = 1'($urandom);
        bus.dec_mem_write = 1'($urandom);
        bus.dec_mem_read  = 1'($urandom);
        bus.dec_branch    = 1'($urandom);
        bus.dec_jump      = 1'($urandom);
        bus.br_taken      = 1'($urandom);
    endtask

    // Compare one cycle at the falling edge, then advance past the next rising edge.
    task automatic cyc(input string tag, input int ireq, input int dreq, input int dwe,
                       input int irl, input int pcl, input int sel, input int rfw,
                       input int bsy, input int hlt, input int er, input int ret);
        logic [11:0] e, o;
        #4;
        e = {ireq[0], dreq[0], dwe[0], irl[0], pcl[0], sel[1:0], rfw[0],
             bsy[0], hlt[0], er[0], ret[0]};
        o = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_load, bus.pc_load,
             bus.pc_sel, bus.rf_we, bus.busy, bus.halted, bus.err, bus.retired};
        check_eq({tag, "_ctl"}, 32'(o), 32'(e));
        check_eq({tag, "_cnt"}, 32'(bus.retired_cnt), 32'(cnt_expected()));
        if (ret != 0 && exp_cnt < CNT_MAX) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    // One reset cycle followed by the all-quiet IDLE cycle.
    task automatic do_reset();
        rand_in();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        rand_in();
        cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic stuck(input string tag, input int hlt, input int er);
        for (int i = 0; i < 3; i++) begin
            rand_in();
            cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, hlt, er, 0);
        end
        do_reset();
    endtask

    // Entered with the sequencer in its first FETCH cycle; leaves it there too.
    task automatic run_instr(input instr_t t);
        int sel;
        int memop;
        for (int k = 0; k < TMO; k++) begin
            rand_in();
            bus.imem_rdy = (k == t.iwait);
            cyc("fetch", 1, 0, 0, int'(k == t.iwait), 0, 0, 0, 1, 0, 0, 0);
            if (k == t.iwait) break;
        end
        if (t.iwait >= TMO) begin
            stuck("ferr", 0, 1);
            return;
        end

        rand_in();
        bus.dec_halt      = (t.halt != 0);
        bus.dec_reg_write = (t.rw != 0);
        bus.dec_mem_write = (t.mw != 0);
        bus.dec_mem_read  = (t.mr != 0);
        bus.dec_branch    = (t.br != 0);
        bus.dec_jump      = (t.jmp != 0);
        cyc("dec", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        if (t.halt != 0) begin
            stuck("halt", 1, 0);
            return;
        end

        rand_in();
        bus.br_taken = (t.bt != 0);
        sel   = (t.jmp != 0) ? 2 : ((t.br != 0 && t.bt != 0) ? 1 : 0);
        memop = int'(t.mw != 0 || t.mr != 0);
        cyc("exec", 0, 0, 0, 0, 1, sel, 0, 1, 0, 0, int'(memop == 0 && t.rw == 0));
        if (memop == 0 && t.rw == 0) return;

        if (memop != 0) begin
            for (int k = 0; k < TMO; k++) begin
                rand_in();
                bus.dmem_rdy = (k == t.dwait);
                if (k == t.rst_at && k < t.dwait) begin
                    rst = 1'b1;
                    cyc("mem_rst", 0, 1, int'(t.mw != 0), 0, 0, 0, 0, 1, 0, 0, 0);
                    rst = 1'b0;
                    exp_cnt = 0;
                    rand_in();
                    cyc("idle_after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    return;
                end
                cyc("mem", 0, 1, int'(t.mw != 0), 0, 0, 0, 0, 1, 0, 0,
                    int'(k == t.dwait && t.mw != 0));
                if (k == t.dwait) break;
            end
            if (t.dwait >= TMO) begin
                stuck("merr", 0, 1);
                return;
            end
            if (t.mw != 0) return;
        end

        rand_in();
        cyc("wb", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    endtask

    function automatic instr_t ins(input int rw, input int mr, input int mw, input int br,
                                   input int jmp, input int bt, input int halt,
                                   input int iw, input int dw, input int rst_at);
        instr_t t;
        t.rw = rw; t.mr = mr; t.mw = mw; t.br = br; t.jmp = jmp; t.bt = bt;
        t.halt = halt; t.iwait = iw; t.dwait = dw; t.rst_at = rst_at;
        return t;
    endfunction

    initial begin
        instr_t t;
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 0;
        rst         = 1'b1;
        rand_in();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rand_in();
        cyc("idle_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Directed cases: ALU, load/store, branch/jump, timeouts, halt, reset in MEM.
        run_instr(ins(1, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        run_instr(ins(1, 1, 0, 0, 0, 0, 0, 1, 3, -1));
        run_instr(ins(0, 0, 1, 0, 0, 0, 0, 0, 3, -1));
        run_instr(ins(1, 1, 1, 0, 0, 0, 0, 2, 1, -1));
        run_instr(ins(0, 0, 0, 1, 0, 1, 0, 0, 0, -1));
        run_instr(ins(0, 0, 0, 1, 1, 1, 0, 0, 0, -1));
        run_instr(ins(0, 0, 0, 1, 0, 0, 0, 0, 0, -1));
        run_instr(ins(1, 0, 0, 0, 0, 0, 0, 14, 0, -1));
        run_instr(ins(0, 1, 0, 0, 0, 0, 0, 0, 14, -1));
        run_instr(ins(1, 0, 0, 0, 0, 0, 0, 15, 0, -1));
        run_instr(ins(0, 1, 0, 0, 0, 0, 0, 0, 15, -1));
        run_instr(ins(1, 0, 0, 0, 0, 0, 1, 0, 0, -1));
        run_instr(ins(0, 1, 0, 0, 0, 0, 0, 0, 5, 2));

        // Enough back-to-back retirements to reach counter saturation.
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            run_instr(ins(0, 0, 0, 0, 0, 0, 0, i % 3, 0, -1));
        end
        run_instr(ins(0, 0, 0, 0, 0, 0, 1, 0, 0, -1));

        // Random instruction mix.
        for (int i = 0; i < 60; i++) begin
            t.rw     = int'($urandom_range(1, 0));
            t.mr     = int'($urandom_range(3, 0) == 0);
            t.mw     = int'($urandom_range(3, 0) == 0);
            t.br     = int'($urandom_range(1, 0));
            t.jmp    = int'($urandom_range(3, 0) == 0);
            t.bt     = int'($urandom_range(1, 0));
            t.halt   = int'($urandom_range(11, 0) == 0);
            t.iwait  = ($urandom_range(11, 0) == 0) ? TMO : int'($urandom_range(4, 0));
            t.dwait  = ($urandom_range(11, 0) == 0) ? TMO : int'($urandom_range(4, 0));
            t.rst_at = ($urandom_range(9, 0) == 0) ? 0 : -1;
            run_instr(t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_seq_ctrl.md
Name: mc_seq_ctrl

Overview:
- Multicycle sequencer for the 5-bit-opcode CPU datapath.
- Consumes the combinational instruction-decoder flags (halt, reg_write, mem_write, sel_wb, branch conditions, jump) and the ALU branch-taken result.
- Steps the shared datapath through fetch/decode/execute/memory/writeback, driving IR/PC/RF enables and the instruction/data memory request handshakes.
- Includes timeout-based error detection.

Parameters:
- MEM_TIMEOUT, 15, max consecutive cycles a memory request may wait for ready before ERR; 0 disables timeout.
- TO_W, 4, width of the timeout counter; must hold MEM_TIMEOUT.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_rdy  in  1  instruction memory ready/data valid
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable, valid with dmem_req
- dmem_rdy  in  1  data memory ready
- dec_halt  in  1  decoder halt flag
- dec_reg_write  in  1  decoder register-write flag
- dec_mem_write  in  1  decoder store flag
- dec_mem_read  in  1  decoder load flag (sel_wb)
- dec_branch  in  1  OR of decoder beqz/bnez/bgez/bltz
- dec_jump  in  1  decoder jump flag
- br_taken  in  1  ALU condition result, sampled in EXEC
- ir_load  out  1  load instruction register
- pc_load  out  1  update PC
- pc_sel  out  2  PC source: 00 seq, 01 branch target, 10 jump target
- rf_we  out  1  register-file write
- busy  out  1  state not in IDLE/HALT/ERR
- halted  out  1  sticky halt indication
- err  out  1  sticky memory-timeout indication
- retired  out  1  one-cycle pulse per completed instruction
- retired_cnt  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- rst high → state IDLE next edge; flags and timeout counter cleared. In IDLE all outputs 0, pc_sel=00, retired_cnt=0.
- Outputs are decoded from state and inputs; no extra latency.
- IDLE → FETCH unconditionally.
- FETCH: imem_req=1, held until imem_rdy. The imem_rdy cycle pulses ir_load=1 → DECODE.
- DECODE: 1 cycle. Latch all dec_* flags into internal regs.
  - dec_halt=1 → HALT; no pc_load, no retire.
  - otherwise → EXEC.
- EXEC: 1 cycle; pc_load=1.
  - pc_sel=10 if jump; else 01 if branch&br_taken; else 00. Jump wins over branch.
  - Next state: mem_write|mem_read → MEM; else reg_write → WB; else FETCH with retired=1.
- MEM: dmem_req=1; dmem_we=latched mem_write. Both req and we are held stable until dmem_rdy.
  - If both mem_write and mem_read are set, treat as a write.
  - On dmem_rdy: read → WB; write → FETCH with retired=1.
- WB: rf_we=1 for 1 cycle → FETCH with retired=1.
- HALT: halted=1 until rst; all requests 0.
- ERR: err=1 until rst; all requests 0.
- Timeout counter:
  - Cleared on entering FETCH/MEM and on any rdy.
  - Increments each cycle the request is high and rdy is low.
  - Reaching MEM_TIMEOUT with rdy still low → ERR next edge.
  - rdy arriving in that same cycle wins; no ERR.
- rdy asserted while no request is outstanding is ignored.
- rst mid-operation (e.g. during MEM): next cycle IDLE, requests drop, no retire pulse, retired_cnt=0.
- busy = state in {FETCH, DECODE, EXEC, MEM, WB}.

Optional Feature:
- Macro: MC_SEQ_PERF_CNT_EN.
- Defined: retired_cnt increments on each retired pulse and saturates at all-ones; it is not cleared by HALT, only by rst.
- Undefined: retired_cnt tied to 0. The port is still present.

Decomposition:
- Package mc_seq_pkg:
  - state enum (3 bits): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
  - PC_SEL_SEQ=2'b00, PC_SEL_BR=2'b01, PC_SEL_JMP=2'b10.
- Sub-module mem_timeout_cnt (clk, rst, clr, req, rdy, expired), instantiated once and shared by FETCH and MEM.

Test Plan:
- ALU op (reg_write only), imem_rdy on 1st cycle → IDLE,FETCH,DECODE,EXEC,WB,FETCH; rf_we 1 cycle; pc_sel=00; retired pulse; retired_cnt=1.
- Load with dmem_rdy after 3 wait cycles → dmem_req high 4 cycles with dmem_we=0, then WB rf_we=1; store variant → dmem_we=1 and no rf_we.
- Branch with br_taken=1 → EXEC pc_sel=01. Branch with dec_jump also 1 → pc_sel=10. Branch with br_taken=0 → pc_sel=00.
- imem_rdy never asserted, MEM_TIMEOUT=15 → ERR after 15 waiting cycles, err=1, imem_req=0. Variant with rdy in the 15th waiting cycle → DECODE, no ERR.
- dec_halt=1 → HALT; halted=1; subsequent imem_rdy/dmem_rdy pulses ignored; rst → IDLE with halted=0.
- rst asserted during MEM wait → next cycle IDLE, dmem_req=0, no retired pulse, retired_cnt=0 with MC_SEQ_PERF_CNT_EN defined.
